somador_subtrator_seq: RTL and testbench

Parametrised, multi-cycle adder/subtractor for the ULA datapath. It generalises the 4-bit ripple adder/subtractor to WIDTH bits, processing CHUNK bits per clock, LSB chunk first, with a carry register between chunks. It uses a start/done handshake, and registers the carry, overflow and zero flags. The ULA controller uses it where a full-width ripple chain would not meet timing.

---
 rtl/somador_subtrator_seq_if.sv | 22 ++
 rtl/somador_subtrator_seq.sv | 89 ++++++++
 tb/tb_somador_subtrator_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/somador_subtrator_seq_if.sv
// somador_subtrator_seq_if: start/done handshake, operands and flagged result of the chunked adder/subtractor
interface somador_subtrator_seq_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             modo_sub;
    logic             cin_inicial;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ov;
    logic             zero;
    modport master (
        output start, a, b, modo_sub, cin_inicial,
        input  ready, done, s, cout, ov, zero
    );
    modport slave (
        input  start, a, b, modo_sub, cin_inicial,
        output ready, done, s, cout, ov, zero
    );
endinterface

// File: rtl/somador_subtrator_seq.sv
// somador_subtrator_seq: multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock; SOMADOR_SATURACAO_EN enables overflow saturation
module somador_subtrator_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    somador_subtrator_seq_if.slave    bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [KW-1:0]    k;
    logic [CHUNK:0]   soma;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] res;
    logic             last;
    logic             c_msb;
    logic             ov_n;
    // Operands shift right each RUN edge so the active chunk is always the low CHUNK bits; the
    // sum chunk enters the result from the top, landing at [k*CHUNK +: CHUNK] after the last edge.
    always_comb begin
        soma  = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
        acc_n = WIDTH'({soma[CHUNK-1:0], acc} >> CHUNK);
        last  = k == KW'(N - 1);
        c_msb = a_r[CHUNK-1] ^ b_r[CHUNK-1] ^ soma[CHUNK-1];
        ov_n  = c_msb ^ soma[CHUNK];
`ifdef SOMADOR_SATURACAO_EN
        res   = ov_n ? {~soma[CHUNK-1], {(WIDTH-1){soma[CHUNK-1]}}} : acc_n;
`else
        res   = acc_n;
`endif
    end
    // Control FSM with registered handshake and result; outputs only move on the final chunk or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            k         <= '0;
            bus.ready <= 1'b1;
            bus.done  <= 1'b0;
            bus.s     <= '0;
            bus.cout  <= 1'b0;
            bus.ov    <= 1'b0;
            bus.zero  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_r       <= bus.a;
                        b_r       <= bus.b ^ {WIDTH{bus.modo_sub}};
                        carry     <= bus.cin_inicial ^ bus.modo_sub;
                        k         <= '0;
                        bus.ready <= 1'b0;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_n;
                    a_r   <= a_r >> CHUNK;
                    b_r   <= b_r >> CHUNK;
                    carry <= soma[CHUNK];
                    k     <= k + 1'b1;
                    if (last) begin
                        state     <= DONE;
                        bus.ready <= 1'b1;
                        bus.done  <= 1'b1;
                        bus.s     <= res;
                        bus.cout  <= soma[CHUNK];
                        bus.ov    <= ov_n;
                        bus.zero  <= res == '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_somador_subtrator_seq.sv
// tb_somador_subtrator_seq: randomized scoreboard bench for somador_subtrator_seq (WIDTH=8, CHUNK=4)
module tb_somador_subtrator_seq;
    localparam int W = 8;
    localparam int C = 4;
    localparam int N = W / C;
    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ov;
        logic         zero;
    } res_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    res_t exp_q[$];
    int   acc_q[$];
    int   checks = 0;
    int   failures = 0;
    int   ncyc = 0;
    int   dones = 0;
    res_t e;
    res_t got;
    int   t0;
    int   d0;
    always #5 clk = ~clk;
    somador_subtrator_seq_if #(.WIDTH(W)) bus();
    somador_subtrator_seq #(.WIDTH(W), .CHUNK(C)) dut (.clk(clk), .rst(rst), .bus(bus));
    // Reference: true signed/unsigned arithmetic on integers.
    function automatic res_t model(input int a, input int b, input bit sub, input bit cin);
        int   sa;
        int   sb;
        int   full;
        int   sv;
        res_t r;
        sa = a > 127 ? a - 256 : a;
        sb = b > 127 ? b - 256 : b;
        if (sub) begin
            full = a - b - int'(cin) + 256;
            sv   = sa - sb - int'(cin);
        end else begin
            full = a + b + int'(cin);
            sv   = sa + sb + int'(cin);
        end
        r.s    = 8'(full % 256);
        r.cout = full >= 256;
        r.ov   = sv > 127 || sv < -128;
`ifdef SOMADOR_SATURACAO_EN
        if (r.ov) r.s = sv > 127 ? 8'h7F : 8'h80;
`endif
        r.zero = r.s == 0;
        return r;
    endfunction
    // Monitor: pushes the expectation on each accepting edge, pops and compares on each done.
    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            if (bus.done) begin
                dones++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_done at cycle %0d s=%0h", ncyc, bus.s);
                end else begin
                    e   = exp_q.pop_front();
                    t0  = acc_q.pop_front();
                    got = {bus.s, bus.cout, bus.ov, bus.zero};
                    if (got !== e) begin
                        failures++;
                        $display("FAIL result got s=%0h cout=%0b ov=%0b zero=%0b exp s=%0h cout=%0b ov=%0b zero=%0b",
                                 got.s, got.cout, got.ov, got.zero, e.s, e.cout, e.ov, e.zero);
                    end
                    checks++;
                    if (ncyc - t0 != N + 1) begin
                        failures++;
                        $display("FAIL latency got=%0d exp=%0d", ncyc - t0 - 1, N);
                    end
                end
            end
            if (bus.start && bus.ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.modo_sub, bus.cin_inicial));
                acc_q.push_back(ncyc);
            end
        end
    end
    task automatic chk(input string name, input logic [31:0] g, input logic [31:0] x);
        checks++;
        if (g !== x) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, g, x);
        end
    endtask
    task automatic wait_ready();
        int i = 0;
        while (!bus.ready && i < 20) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (!bus.ready) chk("ready_timeout", 32'(bus.ready), 32'd1);
    endtask
    task automatic wait_idle();
        int i = 0;
        while (exp_q.size() != 0 && i < 20) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (exp_q.size() != 0) chk("idle_timeout", 32'(exp_q.size()), 32'd0);
    endtask
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin);
        wait_ready();
        bus.a           = a;
        bus.b           = b;
        bus.modo_sub    = sub;
        bus.cin_inicial = cin;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start       = 1'b0;
        bus.a           = W'($urandom);
        bus.b           = W'($urandom);
        bus.modo_sub    = 1'($urandom);
        bus.cin_inicial = 1'($urandom);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.modo_sub = 1'b0;
        bus.cin_inicial = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {bus.s, bus.cout, bus.ov, bus.zero, bus.done, bus.ready}, {8'h00, 5'b00001});
        rst = 1'b0;
        op(8'h3C, 8'h15, 1'b0, 1'b0);
        wait_idle();
        op(8'h22, 8'h33, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("ready_low_in_run", 32'(bus.ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_outputs", {bus.s, bus.cout, bus.ov, bus.zero, bus.done}, 12'h000);
        chk("abort_ready", 32'(bus.ready), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("no_done_after_abort", 32'(bus.done), 32'd0);
        end
        op(8'h01, 8'h01, 1'b0, 1'b0);
        wait_idle();
        chk("after_abort_sum", 32'(bus.s), 32'h02);
        op(8'h10, 8'h20, 1'b1, 1'b0);
        op(8'h20, 8'h20, 1'b1, 1'b0);
        op(8'h7F, 8'h01, 1'b0, 1'b0);
        op(8'h80, 8'h01, 1'b1, 1'b0);
        op(8'h05, 8'h03, 1'b1, 1'b1);
        op(8'hFF, 8'h00, 1'b0, 1'b1);
        wait_idle();
        d0 = dones;
        bus.a = 8'h7F;
        bus.b = 8'h01;
        bus.modo_sub = 1'b0;
        bus.cin_inicial = 1'b0;
        bus.start = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();
        chk("held_start_dones", 32'(dones - d0), 32'd3);
        op(8'h11, 8'h22, 1'b0, 1'b0);
        bus.a = 8'hAA;
        bus.b = 8'h55;
        bus.modo_sub = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();
        chk("ignored_start_s", 32'(bus.s), 32'h33);
        repeat (150) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        wait_idle();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
